fiber_frame_packer: RTL and testbench

- Transmit end of the crate fiber link. Buffers incoming hit coordinates and, on a frame request, serialises them into the fiber frame that the crate mapping receivers decode.
- Frame format: sync word on fiber, then 16 data beats on fxch00..fxch15, then an ID word, then a mandatory gap.
- Sits in the front-end board between the hit finder and the fiber serialiser.

---
 rtl/fiber_frame_packer.sv | 165 ++++++++++++++++
 tb/tb_fiber_frame_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fiber_frame_packer.sv
// Transmit side of the crate fiber link: buffers hit coordinates and emits sync / 16 data beats / ID / gap frames.
// Build option FIBER_PACKER_DROP_CNT_EN adds a saturating drop_cnt output.
module fiber_frame_packer #(
  parameter logic [9:0]  FIBER_ID  = 10'd1,
  parameter logic [15:0] SYNC_WORD = 16'hAAAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic [5:0]  hit_x,
  input  logic [5:0]  hit_y,
  input  logic        frame_req,
  output logic        frame_busy,
  output logic [8:0]  frame_hits,
  output logic [15:0] fiber,
  output logic [15:0] fxch00,
  output logic [15:0] fxch01,
  output logic [15:0] fxch02,
  output logic [15:0] fxch03,
  output logic [15:0] fxch04,
  output logic [15:0] fxch05,
  output logic [15:0] fxch06,
  output logic [15:0] fxch07,
  output logic [15:0] fxch08,
  output logic [15:0] fxch09,
  output logic [15:0] fxch10,
  output logic [15:0] fxch11,
  output logic [15:0] fxch12,
  output logic [15:0] fxch13,
  output logic [15:0] fxch14,
  output logic [15:0] fxch15
`ifdef FIBER_PACKER_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, ID, GAP} state_t;

  state_t      state;
  logic [3:0]  beat;
  logic [8:0]  cnt;
  logic        pending;
  logic [15:0] lane_q [16];
  logic [15:0] mem [16][16];

  logic        accept;
  logic        hit_zero;
  logic        launch;
  logic [8:0]  cnt_acc;
  logic [3:0]  load_beat;
  logic [15:0] beat_words [16];

  // Handshake: a hit transfers on a clk edge where hit_valid && hit_ready; hit_valid must hold its
  // coordinates until then, and hit_ready is registered so it never depends on hit_valid.
  always_comb begin
    accept    = hit_valid && hit_ready;
    hit_zero  = (hit_x == 6'd0) || (hit_y == 6'd0);
    cnt_acc   = (accept && !hit_zero) ? cnt + 9'd1 : cnt;
    launch    = (state == IDLE) && (frame_req || pending);
    load_beat = (state == SYNC) ? 4'd0 : beat + 4'd1;
    for (int l = 0; l < 16; l++) begin
      beat_words[4'(l)] = '0;
      if ({1'b0, load_beat, 4'(l)} < frame_hits)
        beat_words[4'(l)] = mem[4'(l)][load_beat];
    end
  end

  // Storage needs no reset: entries are only read below the frame's captured fill count.
  always_ff @(posedge clk) begin
    if (rst && accept && !hit_zero)
      mem[cnt[3:0]][cnt[7:4]] <= {3'b000, 1'b1, hit_x - 6'd1, hit_y - 6'd1};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      hit_ready  <= 1'b0;
      frame_busy <= 1'b0;
      frame_hits <= '0;
      fiber      <= '0;
      for (int l = 0; l < 16; l++) lane_q[4'(l)] <= '0;
    end else begin
      fiber <= '0;
      for (int l = 0; l < 16; l++) lane_q[4'(l)] <= '0;
      if (state != IDLE && frame_req) pending <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= cnt_acc;
          if (launch) begin
            state      <= SYNC;
            pending    <= 1'b0;
            frame_hits <= cnt_acc;
            frame_busy <= 1'b1;
            hit_ready  <= 1'b0;
            fiber      <= SYNC_WORD;
          end else begin
            hit_ready <= !cnt_acc[8];
          end
        end
        SYNC: begin
          state <= DATA;
          beat  <= load_beat;
          for (int l = 0; l < 16; l++) lane_q[4'(l)] <= beat_words[4'(l)];
        end
        DATA: begin
          if (beat == 4'd15) begin
            state <= ID;
            fiber <= {6'b0, FIBER_ID};
            cnt   <= '0;
          end else begin
            beat <= load_beat;
            for (int l = 0; l < 16; l++) lane_q[4'(l)] <= beat_words[4'(l)];
          end
        end
        ID: begin
          state <= GAP;
        end
        GAP: begin
          state      <= IDLE;
          frame_busy <= 1'b0;
          hit_ready  <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign fxch00 = lane_q[0];
  assign fxch01 = lane_q[1];
  assign fxch02 = lane_q[2];
  assign fxch03 = lane_q[3];
  assign fxch04 = lane_q[4];
  assign fxch05 = lane_q[5];
  assign fxch06 = lane_q[6];
  assign fxch07 = lane_q[7];
  assign fxch08 = lane_q[8];
  assign fxch09 = lane_q[9];
  assign fxch10 = lane_q[10];
  assign fxch11 = lane_q[11];
  assign fxch12 = lane_q[12];
  assign fxch13 = lane_q[13];
  assign fxch14 = lane_q[14];
  assign fxch15 = lane_q[15];

`ifdef FIBER_PACKER_DROP_CNT_EN
  logic drop_inc;

  always_comb drop_inc = (accept && hit_zero) || (hit_valid && state == IDLE && cnt == 9'd256);

  always_ff @(posedge clk) begin
    if (!rst)
      drop_cnt <= '0;
    else if (drop_inc && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fiber_frame_packer.sv
// Bench for fiber_frame_packer: directed hits and frame requests; a negedge monitor checks each
// frame beat by beat against the expected-word queue filled by the stimulus.
`timescale 1ns/1ps
module tb_fiber_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hit_valid = 1'b0;
  logic        frame_req = 1'b0;
  logic [5:0]  hit_x = '0;
  logic [5:0]  hit_y = '0;
  logic        hit_ready;
  logic        frame_busy;
  logic [8:0]  frame_hits;
  logic [15:0] fiber;
  logic [15:0] fx [16];
`ifdef FIBER_PACKER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fiber_frame_packer dut (
    .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_x(hit_x), .hit_y(hit_y), .frame_req(frame_req), .frame_busy(frame_busy),
    .frame_hits(frame_hits), .fiber(fiber),
    .fxch00(fx[0]), .fxch01(fx[1]), .fxch02(fx[2]), .fxch03(fx[3]),
    .fxch04(fx[4]), .fxch05(fx[5]), .fxch06(fx[6]), .fxch07(fx[7]),
    .fxch08(fx[8]), .fxch09(fx[9]), .fxch10(fx[10]), .fxch11(fx[11]),
    .fxch12(fx[12]), .fxch13(fx[13]), .fxch14(fx[14]), .fxch15(fx[15])
`ifdef FIBER_PACKER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rst_s   = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= rst;
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [8:0]  exp_n_q[$];
  logic [15:0] mdl_q[$];
  int          sync_cyc_q[$];
  int          ph  = 0;
  int          rem = 0;
  logic [8:0]  cur_n = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic        lz;
    logic [15:0] w;
    int          k;
    lz = 1'b1;
    for (int l = 0; l < 16; l++) if (fx[l] !== 16'h0) lz = 1'b0;
    if (!rst_s) begin
      check("reset_outs", {hit_ready, frame_busy, frame_hits, fiber, lz},
            {1'b0, 1'b0, 9'd0, 16'h0000, 1'b1});
      for (int i = 0; i < rem; i++) if (exp_q.size() != 0) void'(exp_q.pop_front());
      rem = 0;
      ph  = 0;
    end else if (ph == 0) begin
      if (frame_busy !== 1'b0 || fiber !== 16'h0) begin
        check("sync_word", {frame_busy, fiber, lz}, {1'b1, 16'hAAAA, 1'b1});
        sync_cyc_q.push_back(cyc);
        check("frame_expected", exp_n_q.size() != 0, 1);
        cur_n = (exp_n_q.size() != 0) ? exp_n_q.pop_front() : 9'd0;
        rem   = int'(cur_n);
        check("frame_hits", frame_hits, cur_n);
        ph = 1;
      end else begin
        check("idle_lanes", lz, 1);
      end
    end else if (ph <= 16) begin
      k = ph - 1;
      check($sformatf("beat%0d_fiber_busy", k), {frame_busy, fiber}, {1'b1, 16'h0000});
      for (int l = 0; l < 16; l++) begin
        w = 16'h0000;
        if (k * 16 + l < int'(cur_n)) begin
          w = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hDEAD;
          rem--;
        end
        check($sformatf("beat%0d_lane%0d", k, l), fx[l], w);
      end
      ph++;
    end else if (ph == 17) begin
      check("id_word", {frame_busy, fiber, lz}, {1'b1, 16'h0001, 1'b1});
      ph = 18;
    end else begin
      check("gap", {frame_busy, fiber, lz}, {1'b1, 16'h0000, 1'b1});
      ph = 0;
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_hit(input logic [5:0] x, input logic [5:0] y,
                          input logic store, input logic [15:0] word);
    int t;
    t = 0;
    hit_valid = 1'b1;
    hit_x     = x;
    hit_y     = y;
    while (hit_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("hit_accept_wait", t < 1000, 1);
    @(negedge clk);
    hit_valid = 1'b0;
    if (store) mdl_q.push_back(word);
  endtask

  task automatic frame_pulse();
    exp_n_q.push_back(9'(mdl_q.size()));
    while (mdl_q.size() != 0) exp_q.push_back(mdl_q.pop_front());
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((ph != 0 || exp_n_q.size() != 0 || frame_busy !== 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", t < 2000, 1);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          base;
    int          t;
    int          b;
    logic [5:0]  x;
    logic [5:0]  y;
    logic [15:0] w;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", hit_ready, 1);

    // Two real hits plus three zero-coordinate hits that must be discarded.
    send_hit(6'd1, 6'd19, 1'b1, 16'h1012);
    send_hit(6'd5, 6'd0, 1'b0, 16'h0);
    send_hit(6'd9, 6'd0, 1'b0, 16'h0);
    send_hit(6'd38, 6'd26, 1'b1, 16'h1959);
    send_hit(6'd0, 6'd0, 1'b0, 16'h0);
    frame_pulse();
    wait_idle();

    // Fill the buffer completely, then offer a 257th hit for two cycles.
    for (int i = 0; i < 256; i++) begin
      x = 6'((i % 63) + 1);
      y = 6'(((i * 5) % 63) + 1);
      w = 16'h1000 + (16'(x) - 16'd1) * 16'd64 + (16'(y) - 16'd1);
      send_hit(x, y, 1'b1, w);
    end
    hit_valid = 1'b1;
    hit_x     = 6'd7;
    hit_y     = 6'd7;
    check("full_ready_low_a", hit_ready, 0);
    @(negedge clk);
    check("full_ready_low_b", hit_ready, 0);
    @(negedge clk);
    hit_valid = 1'b0;
`ifdef FIBER_PACKER_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 16'd5);
`endif
    frame_pulse();
    wait_idle();
    check("ready_after_full_frame", hit_ready, 1);

    // Empty-buffer frame; busy must span exactly sync..gap.
    frame_pulse();
    b = 0;
    while (frame_busy === 1'b1 && b < 100) begin
      b++;
      @(negedge clk);
    end
    check("busy_cycles", b, 19);
    wait_idle();

    // Hit accepted on the launching edge is carried by that frame.
    check("ready_same_edge", hit_ready, 1);
    hit_valid = 1'b1;
    hit_x     = 6'd4;
    hit_y     = 6'd5;
    mdl_q.push_back(16'h10C4);
    frame_pulse();
    hit_valid = 1'b0;
    wait_idle();

    // frame_req held: back-to-back frames, then one pending frame after release.
    base = sync_cyc_q.size();
    repeat (4) exp_n_q.push_back(9'd0);
    frame_req = 1'b1;
    t = 0;
    while (sync_cyc_q.size() < base + 3 && t < 200) begin
      @(negedge clk);
      t++;
    end
    frame_req = 1'b0;
    wait_idle();
    check("held_frame_count", sync_cyc_q.size() - base, 4);
    for (int i = 1; i < 4; i++)
      if (sync_cyc_q.size() > base + i)
        check($sformatf("sync_spacing%0d", i), sync_cyc_q[base + i] - sync_cyc_q[base + i - 1], 20);

    // Reset during beat 5 aborts the frame and empties the buffer.
    send_hit(6'd2, 6'd3, 1'b1, 16'h1042);
    send_hit(6'd63, 6'd63, 1'b1, 16'h1FBE);
    frame_pulse();
    repeat (6) @(negedge clk);
    rst = 1'b0;
    mdl_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_abort", hit_ready, 1);
`ifdef FIBER_PACKER_DROP_CNT_EN
    check("drop_cnt_reset", drop_cnt, 16'd0);
`endif
    frame_pulse();
    wait_idle();

    check("frames_left", exp_n_q.size(), 0);
    check("words_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
